dmi_target_regs: RTL and testbench

DMI responder: the debug-module-side end of the DMI request/response channel that the JTAG DTM drives through its CDC. It accepts one DMI request at a time over a valid/ready handshake and executes it against a small local register bank. It then returns a response over a second valid/ready handshake. Writes are gated by the JTAG unlock flag, and rejected writes are counted for debug visibility.

---
 rtl/dmi_target_regs.sv | 228 ++++++++++++++++++++++
 tb/tb_dmi_target_regs.sv | 499 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmi_target_regs.sv
// -----------------------------------------------------------------------------
// dmi_target_regs
//
// Debug-module-side DMI responder. Accepts one request at a time over a
// valid/ready handshake, spends AccessLatency cycles in Exec, then applies the
// access to a small register bank. The result is returned over a second
// valid/ready handshake. Writes are allowed only while the JTAG unlock flag
// was high in the accept cycle. Rejected (locked) writes are counted in a
// saturating 8-bit counter that is visible through the status register.
//
// Ports
//   clk_i             DM clock
//   rst_ni            asynchronous active-low reset
//   jtag_unlock_i     write permission, sampled in the accept cycle only
//   dmi_req_valid_i   request valid
//   dmi_req_ready_o   request ready (high only in Idle)
//   dmi_req_addr_i    7-bit register address
//   dmi_req_op_i      0 NOP, 1 READ, 2 WRITE, 3 PASS
//   dmi_req_data_i    write data
//   dmi_resp_valid_o  response valid (high only in Resp)
//   dmi_resp_ready_i  response ready
//   dmi_resp_data_o   response data, held stable while valid
//   dmi_resp_resp_o   0 success, 2 failed
//   ctrl_o            current value of the ctrl register
//
// Register map
//   0x04+i  data[i]  RW   (i < NumData)
//   0x10    ctrl     RW
//   0x11    status   RO   {16'h0, rej_cnt, 7'h0, unlock}
//   0x12    rej_clr  WO   any write clears rej_cnt, reads return 0
// -----------------------------------------------------------------------------
module dmi_target_regs #(
   parameter int NumData       = 4,
   parameter int AccessLatency = 1
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        jtag_unlock_i,
   input  logic        dmi_req_valid_i,
   output logic        dmi_req_ready_o,
   input  logic [6:0]  dmi_req_addr_i,
   input  logic [1:0]  dmi_req_op_i,
   input  logic [31:0] dmi_req_data_i,
   output logic        dmi_resp_valid_o,
   input  logic        dmi_resp_ready_i,
   output logic [31:0] dmi_resp_data_o,
   output logic [1:0]  dmi_resp_resp_o,
   output logic [31:0] ctrl_o
);

   localparam logic [6:0] AddrDataBase = 7'h04;
   localparam logic [6:0] AddrDataEnd  = 7'(4 + NumData);
   localparam logic [6:0] AddrCtrl     = 7'h10;
   localparam logic [6:0] AddrStatus   = 7'h11;
   localparam logic [6:0] AddrRejClr   = 7'h12;

   localparam logic [1:0] OpRead   = 2'd1;
   localparam logic [1:0] OpWrite  = 2'd2;
   localparam logic [1:0] RespOk   = 2'd0;
   localparam logic [1:0] RespFail = 2'd2;

   localparam logic [3:0] LatInit = 4'(AccessLatency - 1);

   typedef enum logic [1:0] {
      StIdle,
      StExec,
      StResp
   } state_e;

   state_e      state_reg, state_next;
   logic [3:0]  lat_cnt_reg;
   logic [6:0]  addr_reg;
   logic [1:0]  op_reg;
   logic [31:0] wdata_reg;
   logic        unlock_reg;
   logic [31:0] ctrl_reg;
   logic [7:0]  rej_cnt_reg;
   logic [31:0] resp_data_reg;
   logic [1:0]  resp_code_reg;
   logic [31:0] data_val [NumData];

   logic        accept;
   logic        exec_fire;
   logic        is_data;
   logic        rd_mapped;
   logic        writable;
   logic [31:0] rd_value;
   logic [31:0] exec_data;
   logic [1:0]  exec_code;
   logic        wr_en;
   logic        rej_inc;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_reg <= StIdle;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next       = state_reg;
      dmi_req_ready_o  = 1'b0;
      dmi_resp_valid_o = 1'b0;
      case (state_reg)
         StIdle: begin
            dmi_req_ready_o = 1'b1;
            if (dmi_req_valid_i) state_next = StExec;
         end
         StExec: begin
            if (lat_cnt_reg == 4'd0) state_next = StResp;
         end
         StResp: begin
            dmi_resp_valid_o = 1'b1;
            if (dmi_resp_ready_i) state_next = StIdle;
         end
         default: state_next = StIdle;
      endcase
   end

   assign accept    = (state_reg == StIdle) && dmi_req_valid_i;
   assign exec_fire = (state_reg == StExec) && (lat_cnt_reg == 4'd0);

   // ---------------------------------------------- request capture, latency
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         addr_reg    <= '0;
         op_reg      <= '0;
         wdata_reg   <= '0;
         unlock_reg  <= 1'b0;
         lat_cnt_reg <= '0;
      end else if (accept) begin
         addr_reg    <= dmi_req_addr_i;
         op_reg      <= dmi_req_op_i;
         wdata_reg   <= dmi_req_data_i;
         unlock_reg  <= jtag_unlock_i;
         lat_cnt_reg <= LatInit;
      end else if ((state_reg == StExec) && (lat_cnt_reg != 4'd0)) begin
         lat_cnt_reg <= lat_cnt_reg - 4'd1;
      end
   end

   // ------------------------------------------------------ address decode
   always_comb begin
      is_data   = (addr_reg >= AddrDataBase) && (addr_reg < AddrDataEnd);
      rd_value  = '0;
      rd_mapped = 1'b0;
      if (is_data) begin
         rd_mapped = 1'b1;
         for (int i = 0; i < NumData; i++) begin
            if (addr_reg == 7'(4 + i)) rd_value = data_val[i];
         end
      end else if (addr_reg == AddrCtrl) begin
         rd_mapped = 1'b1;
         rd_value  = ctrl_reg;
      end else if (addr_reg == AddrStatus) begin
         rd_mapped = 1'b1;
         rd_value  = {16'h0, rej_cnt_reg, 7'h0, unlock_reg};
      end else if (addr_reg == AddrRejClr) begin
         rd_mapped = 1'b1;
      end
      writable = is_data || (addr_reg == AddrCtrl) || (addr_reg == AddrRejClr);
   end

   // ------------------------------------------------ execution outcome
   always_comb begin
      exec_data = '0;
      exec_code = RespOk;
      wr_en     = 1'b0;
      rej_inc   = 1'b0;
      case (op_reg)
         OpRead: begin
            if (rd_mapped) exec_data = rd_value;
            else           exec_code = RespFail;
         end
         OpWrite: begin
            if (!unlock_reg) begin
               // Only locked writes count as rejections; bad targets do not.
               exec_code = RespFail;
               rej_inc   = 1'b1;
            end else if (writable) begin
               wr_en     = 1'b1;
               exec_data = wdata_reg;
            end else begin
               exec_code = RespFail;
            end
         end
         default: ;  // NOP and PASS: no side effect, success
      endcase
   end

   // ------------------------------------------------------ register bank
   for (genvar gi = 0; gi < NumData; gi++) begin : g_data
      logic [31:0] data_reg;
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            data_reg <= '0;
         end else if (exec_fire && wr_en && (addr_reg == 7'(4 + gi))) begin
            data_reg <= wdata_reg;
         end
      end
      assign data_val[gi] = data_reg;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ctrl_reg      <= '0;
         rej_cnt_reg   <= '0;
         resp_data_reg <= '0;
         resp_code_reg <= RespOk;
      end else if (exec_fire) begin
         if (wr_en && (addr_reg == AddrCtrl)) ctrl_reg <= wdata_reg;
         if (wr_en && (addr_reg == AddrRejClr)) begin
            rej_cnt_reg <= '0;
         end else if (rej_inc && (rej_cnt_reg != 8'hFF)) begin
            rej_cnt_reg <= rej_cnt_reg + 8'd1;
         end
         resp_data_reg <= exec_data;
         resp_code_reg <= exec_code;
      end
   end

   assign dmi_resp_data_o = resp_data_reg;
   assign dmi_resp_resp_o = resp_code_reg;
   assign ctrl_o          = ctrl_reg;

endmodule

// File: tb/tb_dmi_target_regs.sv
// -----------------------------------------------------------------------------
// tb_dmi_target_regs
//
// Directed self-checking bench for dmi_target_regs with default parameters
// (NumData=4, AccessLatency=1). Each task drives one scenario and checks the
// responses against hand-computed values.
// -----------------------------------------------------------------------------
module tb_dmi_target_regs;

   localparam logic [1:0] OP_NOP   = 2'd0;
   localparam logic [1:0] OP_READ  = 2'd1;
   localparam logic [1:0] OP_WRITE = 2'd2;
   localparam logic [1:0] OP_PASS  = 2'd3;

   logic        clk;
   logic        rst_ni;
   logic        jtag_unlock_i;
   logic        dmi_req_valid_i;
   logic        dmi_req_ready_o;
   logic [6:0]  dmi_req_addr_i;
   logic [1:0]  dmi_req_op_i;
   logic [31:0] dmi_req_data_i;
   logic        dmi_resp_valid_o;
   logic        dmi_resp_ready_i;
   logic [31:0] dmi_resp_data_o;
   logic [1:0]  dmi_resp_resp_o;
   logic [31:0] ctrl_o;

   int tests_run    = 0;
   int tests_failed = 0;

   dmi_target_regs #(
      .NumData       (4),
      .AccessLatency (1)
   ) dut (
      .clk_i            (clk),
      .rst_ni           (rst_ni),
      .jtag_unlock_i    (jtag_unlock_i),
      .dmi_req_valid_i  (dmi_req_valid_i),
      .dmi_req_ready_o  (dmi_req_ready_o),
      .dmi_req_addr_i   (dmi_req_addr_i),
      .dmi_req_op_i     (dmi_req_op_i),
      .dmi_req_data_i   (dmi_req_data_i),
      .dmi_resp_valid_o (dmi_resp_valid_o),
      .dmi_resp_ready_i (dmi_resp_ready_i),
      .dmi_resp_data_o  (dmi_resp_data_o),
      .dmi_resp_resp_o  (dmi_resp_resp_o),
      .ctrl_o           (ctrl_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One full transaction. After the accept edge the unlock input is flipped,
   // so every transaction also shows that only the accept-cycle value counts.
   task automatic do_txn(input logic [1:0] op, input logic [6:0] addr,
                         input logic [31:0] wdata, input logic unlock,
                         output logic [31:0] rdata, output logic [1:0] rresp,
                         output int lat);
      int guard;
      rdata = 32'hFFFF_FFFF;
      rresp = 2'b11;
      lat   = -1;
      @(negedge clk);
      dmi_req_valid_i = 1'b1;
      dmi_req_op_i    = op;
      dmi_req_addr_i  = addr;
      dmi_req_data_i  = wdata;
      jtag_unlock_i   = unlock;
      guard = 0;
      while (!dmi_req_ready_o && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 50) begin
         tests_run++;
         tests_failed++;
         $display("FAIL txn_accept_timeout: ready=%b required 1", dmi_req_ready_o);
         dmi_req_valid_i = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      dmi_req_valid_i = 1'b0;
      jtag_unlock_i   = ~unlock;
      lat = 0;
      forever begin
         @(negedge clk);
         if (dmi_resp_valid_o || lat >= 50) break;
         lat++;
      end
      if (!dmi_resp_valid_o) begin
         tests_run++;
         tests_failed++;
         $display("FAIL txn_resp_timeout: resp_valid=%b required 1", dmi_resp_valid_o);
         return;
      end
      rdata = dmi_resp_data_o;
      rresp = dmi_resp_resp_o;
      dmi_resp_ready_i = 1'b1;
      @(posedge clk);
      #1;
      dmi_resp_ready_i = 1'b0;
      $display("[TB] txn op=%0d addr=%02h wdata=%08h unlock=%b -> resp=%0d data=%08h lat=%0d",
               op, addr, wdata, unlock, rresp, rdata, lat);
   endtask

   task automatic test_reset();
      rst_ni           = 1'b0;
      jtag_unlock_i    = 1'b0;
      dmi_req_valid_i  = 1'b0;
      dmi_req_addr_i   = '0;
      dmi_req_op_i     = '0;
      dmi_req_data_i   = '0;
      dmi_resp_ready_i = 1'b0;
      repeat (3) @(negedge clk);
      tests_run++;
      if (dmi_req_ready_o !== 1'b1) begin
         tests_failed++;
         $display("FAIL reset_req_ready: got %b required 1", dmi_req_ready_o);
      end
      tests_run++;
      if (dmi_resp_valid_o !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_resp_valid: got %b required 0", dmi_resp_valid_o);
      end
      tests_run++;
      if (dmi_resp_data_o !== 32'h0) begin
         tests_failed++;
         $display("FAIL reset_resp_data: got %08h required 00000000", dmi_resp_data_o);
      end
      tests_run++;
      if (dmi_resp_resp_o !== 2'd0) begin
         tests_failed++;
         $display("FAIL reset_resp_code: got %0d required 0", dmi_resp_resp_o);
      end
      tests_run++;
      if (ctrl_o !== 32'h0) begin
         tests_failed++;
         $display("FAIL reset_ctrl: got %08h required 00000000", ctrl_o);
      end
      rst_ni = 1'b1;
      @(negedge clk);
      tests_run++;
      if (dmi_req_ready_o !== 1'b1 || dmi_resp_valid_o !== 1'b0) begin
         tests_failed++;
         $display("FAIL post_reset_idle: ready=%b valid=%b required 1 0",
                  dmi_req_ready_o, dmi_resp_valid_o);
      end
   endtask

   task automatic test_write_read();
      logic [31:0] d;
      logic [1:0]  r;
      int          lat;
      do_txn(OP_WRITE, 7'h05, 32'hDEADBEEF, 1'b1, d, r, lat);
      tests_run++;
      if (r !== 2'd0 || d !== 32'hDEADBEEF) begin
         tests_failed++;
         $display("FAIL write_05: got resp=%0d data=%08h required 0 DEADBEEF", r, d);
      end
      tests_run++;
      if (lat !== 1) begin
         tests_failed++;
         $display("FAIL write_latency: got %0d required 1", lat);
      end
      do_txn(OP_READ, 7'h05, 32'h0, 1'b1, d, r, lat);
      tests_run++;
      if (r !== 2'd0 || d !== 32'hDEADBEEF) begin
         tests_failed++;
         $display("FAIL read_05: got resp=%0d data=%08h required 0 DEADBEEF", r, d);
      end
      do_txn(OP_WRITE, 7'h07, 32'h11112222, 1'b1, d, r, lat);
      do_txn(OP_READ, 7'h04, 32'h0, 1'b1, d, r, lat);
      tests_run++;
      if (r !== 2'd0 || d !== 32'h0) begin
         tests_failed++;
         $display("FAIL read_04: got resp=%0d data=%08h required 0 00000000", r, d);
      end
      do_txn(OP_READ, 7'h07, 32'h0, 1'b0, d, r, lat);
      tests_run++;
      if (r !== 2'd0 || d !== 32'h11112222) begin
         tests_failed++;
         $display("FAIL read_07: got resp=%0d data=%08h required 0 11112222", r, d);
      end
   endtask

   task automatic test_locked_write();
      logic [31:0] d;
      logic [1:0]  r;
      int          lat;
      do_txn(OP_WRITE, 7'h10, 32'h1, 1'b0, d, r, lat);
      tests_run++;
      if (r !== 2'd2 || d !== 32'h0) begin
         tests_failed++;
         $display("FAIL locked_write: got resp=%0d data=%08h required 2 00000000", r, d);
      end
      tests_run++;
      if (ctrl_o !== 32'h0) begin
         tests_failed++;
         $display("FAIL locked_ctrl: got %08h required 00000000", ctrl_o);
      end
      do_txn(OP_READ, 7'h11, 32'h0, 1'b0, d, r, lat);
      tests_run++;
      if (r !== 2'd0 || d !== 32'h00000100) begin
         tests_failed++;
         $display("FAIL status_one_rej: got resp=%0d data=%08h required 0 00000100", r, d);
      end
   endtask

   task automatic test_saturation();
      logic [31:0] d;
      logic [1:0]  r;
      int          lat;
      int          bad;
      bad = 0;
      for (int i = 0; i < 300; i++) begin
         do_txn(OP_WRITE, 7'h04, 32'(i), 1'b0, d, r, lat);
         if (r !== 2'd2) bad++;
      end
      tests_run++;
      if (bad != 0) begin
         tests_failed++;
         $display("FAIL sat_locked_resp: got %0d non-fail responses required 0", bad);
      end
      do_txn(OP_READ, 7'h11, 32'h0, 1'b0, d, r, lat);
      tests_run++;
      if (d !== 32'h0000FF00) begin
         tests_failed++;
         $display("FAIL status_saturated: got %08h required 0000FF00", d);
      end
      do_txn(OP_READ, 7'h04, 32'h0, 1'b1, d, r, lat);
      tests_run++;
      if (d !== 32'h0) begin
         tests_failed++;
         $display("FAIL locked_data04: got %08h required 00000000", d);
      end
      do_txn(OP_WRITE, 7'h12, 32'h5A5A0001, 1'b1, d, r, lat);
      tests_run++;
      if (r !== 2'd0 || d !== 32'h5A5A0001) begin
         tests_failed++;
         $display("FAIL rej_clr_write: got resp=%0d data=%08h required 0 5A5A0001", r, d);
      end
      do_txn(OP_READ, 7'h11, 32'h0, 1'b1, d, r, lat);
      tests_run++;
      if (d !== 32'h00000001) begin
         tests_failed++;
         $display("FAIL status_cleared: got %08h required 00000001", d);
      end
   endtask

   task automatic test_unmapped();
      logic [31:0] d;
      logic [1:0]  r;
      int          lat;
      do_txn(OP_READ, 7'h7F, 32'h0, 1'b1, d, r, lat);
      tests_run++;
      if (r !== 2'd2 || d !== 32'h0) begin
         tests_failed++;
         $display("FAIL read_7F: got resp=%0d data=%08h required 2 00000000", r, d);
      end
      do_txn(OP_READ, 7'h08, 32'h0, 1'b1, d, r, lat);
      tests_run++;
      if (r !== 2'd2 || d !== 32'h0) begin
         tests_failed++;
         $display("FAIL read_08: got resp=%0d data=%08h required 2 00000000", r, d);
      end
      do_txn(OP_READ, 7'h12, 32'h0, 1'b1, d, r, lat);
      tests_run++;
      if (r !== 2'd0 || d !== 32'h0) begin
         tests_failed++;
         $display("FAIL read_rej_clr: got resp=%0d data=%08h required 0 00000000", r, d);
      end
      do_txn(OP_WRITE, 7'h06, 32'h1, 1'b0, d, r, lat);   // rej_cnt -> 1
      do_txn(OP_WRITE, 7'h11, 32'hFFFFFFFF, 1'b1, d, r, lat);
      tests_run++;
      if (r !== 2'd2 || d !== 32'h0) begin
         tests_failed++;
         $display("FAIL write_status: got resp=%0d data=%08h required 2 00000000", r, d);
      end
      do_txn(OP_WRITE, 7'h7F, 32'h12345678, 1'b1, d, r, lat);
      tests_run++;
      if (r !== 2'd2 || d !== 32'h0) begin
         tests_failed++;
         $display("FAIL write_7F: got resp=%0d data=%08h required 2 00000000", r, d);
      end
      do_txn(OP_READ, 7'h11, 32'h0, 1'b0, d, r, lat);
      tests_run++;
      if (d !== 32'h00000100) begin
         tests_failed++;
         $display("FAIL status_unchanged: got %08h required 00000100", d);
      end
      do_txn(OP_PASS, 7'h04, 32'hAAAA5555, 1'b1, d, r, lat);
      tests_run++;
      if (r !== 2'd0 || d !== 32'h0) begin
         tests_failed++;
         $display("FAIL pass_op: got resp=%0d data=%08h required 0 00000000", r, d);
      end
      do_txn(OP_NOP, 7'h10, 32'hAAAA5555, 1'b1, d, r, lat);
      tests_run++;
      if (r !== 2'd0 || d !== 32'h0 || ctrl_o !== 32'h0) begin
         tests_failed++;
         $display("FAIL nop_op: got resp=%0d data=%08h ctrl=%08h required 0 00000000 00000000",
                  r, d, ctrl_o);
      end
      do_txn(OP_READ, 7'h04, 32'h0, 1'b1, d, r, lat);
      tests_run++;
      if (d !== 32'h0) begin
         tests_failed++;
         $display("FAIL pass_no_effect: got %08h required 00000000", d);
      end
      do_txn(OP_WRITE, 7'h10, 32'hA5A50F0F, 1'b1, d, r, lat);
      tests_run++;
      if (ctrl_o !== 32'hA5A50F0F || r !== 2'd0) begin
         tests_failed++;
         $display("FAIL ctrl_write: got ctrl=%08h resp=%0d required A5A50F0F 0", ctrl_o, r);
      end
      do_txn(OP_READ, 7'h10, 32'h0, 1'b0, d, r, lat);
      tests_run++;
      if (d !== 32'hA5A50F0F) begin
         tests_failed++;
         $display("FAIL ctrl_read: got %08h required A5A50F0F", d);
      end
   endtask

   // Response ready held high: each handshake completes in the cycle valid
   // rises, giving a request-to-request period of AccessLatency+2 = 3.
   task automatic test_back_to_back();
      logic exp_ready [6];
      logic exp_valid [6];
      exp_ready = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      exp_valid = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      @(negedge clk);
      dmi_resp_ready_i = 1'b1;
      dmi_req_valid_i  = 1'b1;
      dmi_req_op_i     = OP_READ;
      dmi_req_addr_i   = 7'h07;
      jtag_unlock_i    = 1'b1;
      @(posedge clk);
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         tests_run++;
         if (dmi_req_ready_o !== exp_ready[k] || dmi_resp_valid_o !== exp_valid[k]) begin
            tests_failed++;
            $display("FAIL b2b_cycle%0d: got ready=%b valid=%b required %b %b",
                     k, dmi_req_ready_o, dmi_resp_valid_o, exp_ready[k], exp_valid[k]);
         end
         if (exp_valid[k]) begin
            tests_run++;
            if (dmi_resp_data_o !== 32'h11112222 || dmi_resp_resp_o !== 2'd0) begin
               tests_failed++;
               $display("FAIL b2b_data%0d: got %08h resp=%0d required 11112222 0",
                        k, dmi_resp_data_o, dmi_resp_resp_o);
            end
            $display("[TB] txn b2b read addr=07 -> resp=%0d data=%08h",
                     dmi_resp_resp_o, dmi_resp_data_o);
         end
         if (k == 4) dmi_req_valid_i = 1'b0;
      end
      dmi_resp_ready_i = 1'b0;
   endtask

   task automatic test_backpressure();
      logic [31:0] d;
      logic [1:0]  r;
      int          lat;
      int          guard;
      int          bad;
      logic [31:0] held_data;
      logic [1:0]  held_resp;
      @(negedge clk);
      dmi_req_valid_i = 1'b1;
      dmi_req_op_i    = OP_READ;
      dmi_req_addr_i  = 7'h05;
      jtag_unlock_i   = 1'b1;
      @(posedge clk);
      #1;
      // Second request stays presented on the request port throughout.
      dmi_req_op_i   = OP_WRITE;
      dmi_req_addr_i = 7'h06;
      dmi_req_data_i = 32'hCAFEF00D;
      guard = 0;
      bad   = 0;
      forever begin
         @(negedge clk);
         if (dmi_resp_valid_o || guard >= 50) break;
         if (dmi_req_ready_o !== 1'b0) bad++;
         guard++;
      end
      tests_run++;
      if (!dmi_resp_valid_o || dmi_resp_data_o !== 32'hDEADBEEF || dmi_resp_resp_o !== 2'd0) begin
         tests_failed++;
         $display("FAIL bp_first_resp: got valid=%b data=%08h resp=%0d required 1 DEADBEEF 0",
                  dmi_resp_valid_o, dmi_resp_data_o, dmi_resp_resp_o);
      end
      held_data = dmi_resp_data_o;
      held_resp = dmi_resp_resp_o;
      repeat (10) begin
         @(negedge clk);
         if (dmi_resp_valid_o !== 1'b1 || dmi_resp_data_o !== held_data ||
             dmi_resp_resp_o !== held_resp || dmi_req_ready_o !== 1'b0) bad++;
      end
      tests_run++;
      if (bad != 0) begin
         tests_failed++;
         $display("FAIL bp_hold_stable: got %0d unstable cycles required 0", bad);
      end
      $display("[TB] txn bp read addr=05 -> resp=%0d data=%08h", held_resp, held_data);
      dmi_resp_ready_i = 1'b1;
      @(posedge clk);
      #1;
      dmi_resp_ready_i = 1'b0;
      @(negedge clk);
      tests_run++;
      if (dmi_req_ready_o !== 1'b1 || dmi_resp_valid_o !== 1'b0) begin
         tests_failed++;
         $display("FAIL bp_idle_after_hs: got ready=%b valid=%b required 1 0",
                  dmi_req_ready_o, dmi_resp_valid_o);
      end
      @(posedge clk);
      #1;
      dmi_req_valid_i = 1'b0;
      guard = 0;
      forever begin
         @(negedge clk);
         if (dmi_resp_valid_o || guard >= 50) break;
         guard++;
      end
      tests_run++;
      if (!dmi_resp_valid_o || dmi_resp_data_o !== 32'hCAFEF00D || dmi_resp_resp_o !== 2'd0) begin
         tests_failed++;
         $display("FAIL bp_second_resp: got valid=%b data=%08h resp=%0d required 1 CAFEF00D 0",
                  dmi_resp_valid_o, dmi_resp_data_o, dmi_resp_resp_o);
      end
      $display("[TB] txn bp write addr=06 -> resp=%0d data=%08h", dmi_resp_resp_o, dmi_resp_data_o);
      dmi_resp_ready_i = 1'b1;
      @(posedge clk);
      #1;
      dmi_resp_ready_i = 1'b0;
      do_txn(OP_READ, 7'h06, 32'h0, 1'b1, d, r, lat);
      tests_run++;
      if (r !== 2'd0 || d !== 32'hCAFEF00D) begin
         tests_failed++;
         $display("FAIL bp_readback_06: got resp=%0d data=%08h required 0 CAFEF00D", r, d);
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] d;
      logic [1:0]  r;
      int          lat;
      @(negedge clk);
      dmi_req_valid_i = 1'b1;
      dmi_req_op_i    = OP_WRITE;
      dmi_req_addr_i  = 7'h04;
      dmi_req_data_i  = 32'h55AA55AA;
      jtag_unlock_i   = 1'b1;
      @(posedge clk);
      #1;
      dmi_req_valid_i = 1'b0;
      rst_ni = 1'b0;                 // FSM is in Exec here
      #1;
      tests_run++;
      if (dmi_req_ready_o !== 1'b1 || dmi_resp_valid_o !== 1'b0 || dmi_resp_data_o !== 32'h0 ||
          dmi_resp_resp_o !== 2'd0 || ctrl_o !== 32'h0) begin
         tests_failed++;
         $display("FAIL reset_mid_outputs: got ready=%b valid=%b data=%08h resp=%0d ctrl=%08h required 1 0 00000000 0 00000000",
                  dmi_req_ready_o, dmi_resp_valid_o, dmi_resp_data_o, dmi_resp_resp_o, ctrl_o);
      end
      repeat (2) @(negedge clk);
      rst_ni = 1'b1;
      do_txn(OP_READ, 7'h04, 32'h0, 1'b1, d, r, lat);
      tests_run++;
      if (r !== 2'd0 || d !== 32'h0) begin
         tests_failed++;
         $display("FAIL reset_mid_read04: got resp=%0d data=%08h required 0 00000000", r, d);
      end
      do_txn(OP_READ, 7'h05, 32'h0, 1'b1, d, r, lat);
      tests_run++;
      if (d !== 32'h0) begin
         tests_failed++;
         $display("FAIL reset_mid_read05: got %08h required 00000000", d);
      end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_locked_write();
      test_saturation();
      test_unmapped();
      test_back_to_back();
      test_backpressure();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
